// File: rtl/ipm_route_framer.sv
// ipm_route_framer: valid/ready framing and XY route stage at the front of an input port module.
// Define IPM_FRAMER_TIMEOUT_EN to abandon a packet whose BODY phase stalls for TIMEOUT_CYCLES.
module ipm_route_framer #(
  parameter int unsigned FLIT_WIDTH     = 34,
  parameter int unsigned X_W            = 4,
  parameter int unsigned Y_W            = 4,
  parameter int unsigned LOCAL_X        = 0,
  parameter int unsigned LOCAL_Y        = 0,
  parameter int unsigned OUTPORTPORTS   = 5,
  parameter int unsigned MAX_PKT_LEN    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [FLIT_WIDTH-1:0]   in_flit_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [FLIT_WIDTH-1:0]   out_flit_o,
  output logic [OUTPORTPORTS-1:0] port_sel_o,
  output logic                    PacketEnable_dw_o,
  output logic                    Tailpassed_dw_o,
  output logic                    err_o
);

  localparam int unsigned LEN_W = $clog2(MAX_PKT_LEN + 1);
  localparam int unsigned P_L   = 0;
  localparam int unsigned P_N   = 1;
  localparam int unsigned P_E   = 2;
  localparam int unsigned P_S   = 3;
  localparam int unsigned P_W   = 4;

  typedef enum logic {IDLE, BODY} state_t;

  state_t                  state;
  logic [LEN_W-1:0]        len;
  logic [LEN_W-1:0]        len_base;
  logic                    accept;
  logic                    xfer;
  logic                    in_head;
  logic                    in_tail;
  logic                    fwd;
  logic                    head_start;
  logic                    proto_err;
  logic                    len_err;
  logic                    tail_out;
  logic                    timeout;
  logic [X_W-1:0]          dst_x;
  logic [Y_W-1:0]          dst_y;
  logic [OUTPORTPORTS-1:0] route;

  assign in_ready_o = ~out_valid_o | out_ready_i;
  assign accept     = in_valid_i & in_ready_o;
  assign xfer       = out_valid_o & out_ready_i;
  assign in_head    = in_flit_i[FLIT_WIDTH-2];
  assign in_tail    = in_flit_i[FLIT_WIDTH-1];
  assign tail_out   = xfer & out_flit_o[FLIT_WIDTH-1];

  // IDLE forwards only heads, BODY forwards only body/tail; everything else accepted is dropped
  assign fwd        = accept & ((state == IDLE) ? in_head : ~in_head);
  assign proto_err  = accept & ~fwd;
  assign head_start = fwd & (state == IDLE);
  assign len_base   = (state == IDLE) ? '0 : len;
  assign len_err    = fwd & ~in_tail & (len_base == LEN_W'(MAX_PKT_LEN - 1));

  assign dst_x = in_flit_i[X_W-1:0];
  assign dst_y = in_flit_i[X_W+Y_W-1:X_W];

  // Dimension-order routing: resolve X first, then Y
  always_comb begin
    route = '0;
    if (dst_x > X_W'(LOCAL_X))      route[P_E] = 1'b1;
    else if (dst_x < X_W'(LOCAL_X)) route[P_W] = 1'b1;
    else if (dst_y > Y_W'(LOCAL_Y)) route[P_N] = 1'b1;
    else if (dst_y < Y_W'(LOCAL_Y)) route[P_S] = 1'b1;
    else                            route[P_L] = 1'b1;
  end

`ifdef IPM_FRAMER_TIMEOUT_EN
  localparam int unsigned STALL_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [STALL_W-1:0] stall;

  assign timeout = (state == BODY) & ~accept & (stall == STALL_W'(TIMEOUT_CYCLES - 1));

  // Counts BODY cycles without an input accept
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                    stall <= '0;
    else if ((state != BODY) | accept | timeout)  stall <= '0;
    else                                          stall <= stall + STALL_W'(1);
  end
`else
  // Stall limit is inert in this build
  assign timeout = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      out_valid_o       <= 1'b0;
      out_flit_o        <= '0;
      port_sel_o        <= '0;
      PacketEnable_dw_o <= 1'b0;
      Tailpassed_dw_o   <= 1'b0;
      err_o             <= 1'b0;
      len               <= '0;
    end else begin
      Tailpassed_dw_o <= tail_out;
      err_o           <= proto_err | len_err | timeout;

      if (fwd) begin
        out_valid_o <= 1'b1;
        out_flit_o  <= in_flit_i;
      end else if (xfer) begin
        out_valid_o <= 1'b0;
      end

      if (head_start) begin
        port_sel_o <= route;
        len        <= LEN_W'(1);
      end else if (fwd && (len != LEN_W'(MAX_PKT_LEN))) begin
        len <= len + LEN_W'(1);
      end

      // A new head wins over the previous tail leaving in the same cycle
      if (head_start)            PacketEnable_dw_o <= 1'b1;
      else if (tail_out | timeout) PacketEnable_dw_o <= 1'b0;

      case (state)
        IDLE:    if (head_start & ~in_tail)   state <= BODY;
        BODY:    if ((fwd & in_tail) | timeout) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ipm_route_framer.sv
// tb_ipm_route_framer: directed and random traffic against a per-cycle behavioural model.
module tb_ipm_route_framer;

  localparam int FW  = 34;
  localparam int LX  = 1;
  localparam int LY  = 1;
  localparam int MAX = 4;
  localparam int TMO = 8;

  localparam logic [1:0] T_BODY = 2'b00;
  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_TAIL = 2'b10;
  localparam logic [1:0] T_HT   = 2'b11;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [FW-1:0] in_flit_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [FW-1:0] out_flit_o;
  logic [4:0]    port_sel_o;
  logic          PacketEnable_dw_o;
  logic          Tailpassed_dw_o;
  logic          err_o;

  int n_vec = 0;
  int n_bad = 0;

  // Model state
  logic          m_ov;
  logic [FW-1:0] m_flit;
  logic [4:0]    m_sel;
  logic          m_pe;
  logic          m_tp;
  logic          m_err;
  bit            in_pkt;
  int            len;
  int            stall;

  ipm_route_framer #(
    .FLIT_WIDTH(FW), .X_W(4), .Y_W(4), .LOCAL_X(LX), .LOCAL_Y(LY),
    .OUTPORTPORTS(5), .MAX_PKT_LEN(MAX), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_flit_i(in_flit_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_flit_o(out_flit_o),
    .port_sel_o(port_sel_o), .PacketEnable_dw_o(PacketEnable_dw_o),
    .Tailpassed_dw_o(Tailpassed_dw_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [4:0] route_of(input int dx, input int dy);
    if (dx > LX) return 5'b00100;
    if (dx < LX) return 5'b10000;
    if (dy > LY) return 5'b00010;
    if (dy < LY) return 5'b01000;
    return 5'b00001;
  endfunction

  task automatic model_reset();
    m_ov = 1'b0; m_flit = '0; m_sel = '0; m_pe = 1'b0; m_tp = 1'b0; m_err = 1'b0;
    in_pkt = 1'b0; len = 0; stall = 0;
  endtask

  // One clock: drive inputs, check registered outputs, advance the model
  task automatic step(input logic v, input logic [1:0] typ, input logic [31:0] pay, input logic ordy);
    logic [FW-1:0] f;
    bit rdy, acc, xfer, fwd, err, was_pkt, n_tp, n_pe;
    f = {typ, pay};
    @(negedge clk);
    in_valid_i = v; in_flit_i = f; out_ready_i = ordy;
    #1;
    rdy = !m_ov || ordy;
    check("in_ready",  64'(in_ready_o),        64'(rdy));
    check("out_valid", 64'(out_valid_o),       64'(m_ov));
    check("out_flit",  64'(out_flit_o),        64'(m_flit));
    check("port_sel",  64'(port_sel_o),        64'(m_sel));
    check("pkt_en",    64'(PacketEnable_dw_o), 64'(m_pe));
    check("tailpass",  64'(Tailpassed_dw_o),   64'(m_tp));
    check("err",       64'(err_o),             64'(m_err));

    acc = v && rdy;
    xfer = m_ov && ordy;
    fwd = 1'b0; err = 1'b0;
    was_pkt = in_pkt;
    n_tp = xfer && m_flit[FW-1];
    n_pe = n_tp ? 1'b0 : m_pe;
    if (acc) begin
      if (!in_pkt) begin
        if (typ[0]) begin
          fwd = 1'b1;
          m_sel = route_of(int'(pay[3:0]), int'(pay[7:4]));
          len = 1;
          in_pkt = !typ[1];
          n_pe = 1'b1;
        end else err = 1'b1;
      end else begin
        if (typ[0]) err = 1'b1;
        else begin
          fwd = 1'b1;
          if (!typ[1] && len == MAX - 1) err = 1'b1;
          if (len < MAX) len++;
          if (typ[1]) in_pkt = 1'b0;
        end
      end
    end
`ifdef IPM_FRAMER_TIMEOUT_EN
    if (was_pkt && !acc) begin
      stall++;
      if (stall == TMO) begin
        err = 1'b1; in_pkt = 1'b0; n_pe = 1'b0; stall = 0;
      end
    end else stall = 0;
`else
    if (was_pkt) stall = 0;
`endif
    if (fwd) begin m_ov = 1'b1; m_flit = f; end
    else if (xfer) m_ov = 1'b0;
    m_err = err; m_tp = n_tp; m_pe = n_pe;
  endtask

  task automatic dest(input int x, input int y, output logic [31:0] p);
    p = $urandom;
    p[3:0] = 4'(x);
    p[7:4] = 4'(y);
  endtask

  initial begin
    logic [31:0] p;
    logic [1:0] typ;
    int r;
    reset = 1'b1; in_valid_i = 1'b0; in_flit_i = '0; out_ready_i = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state, then a full packet routed east
    step(0, T_BODY, 32'h0, 1);
    dest(3, 0, p); step(1, T_HEAD, p, 1);
    step(1, T_BODY, $urandom, 1);
    step(1, T_BODY, $urandom, 1);
    step(1, T_TAIL, $urandom, 1);
    repeat (3) step(0, T_BODY, 32'h0, 1);

    // Single-flit packet to the local port
    dest(1, 1, p); step(1, T_HT, p, 1);
    repeat (3) step(0, T_BODY, 32'h0, 1);

    // Stray body in IDLE, then a normal head
    step(1, T_BODY, $urandom, 1);
    dest(1, 5, p); step(1, T_HEAD, p, 1);
    step(1, T_TAIL, $urandom, 1);
    repeat (2) step(0, T_BODY, 32'h0, 1);

    // Downstream stall mid-packet
    dest(0, 1, p); step(1, T_HEAD, p, 1);
    step(1, T_BODY, 32'hA5A5_0001, 1);
    repeat (5) step(1, T_BODY, 32'hA5A5_0002, 0);
    step(1, T_BODY, 32'hA5A5_0002, 1);
    step(1, T_TAIL, 32'hA5A5_0003, 0);
    step(1, T_TAIL, 32'hA5A5_0003, 1);
    repeat (3) step(0, T_BODY, 32'h0, 1);

    // Overlong packet, plus a head in BODY and a back-to-back head after the tail
    dest(1, 0, p); step(1, T_HEAD, p, 1);
    repeat (4) step(1, T_BODY, $urandom, 1);
    step(1, T_HEAD, $urandom, 1);
    step(1, T_TAIL, $urandom, 1);
    dest(7, 7, p); step(1, T_HT, p, 1);
    repeat (2) step(0, T_BODY, 32'h0, 1);

`ifdef IPM_FRAMER_TIMEOUT_EN
    dest(2, 2, p); step(1, T_HEAD, p, 1);
    step(1, T_BODY, $urandom, 1);
    repeat (TMO + 3) step(0, T_BODY, 32'h0, 1);
    dest(1, 1, p); step(1, T_HT, p, 1);
    repeat (2) step(0, T_BODY, 32'h0, 1);
`endif

    // Asynchronous reset between edges, mid-packet
    dest(0, 0, p); step(1, T_HEAD, p, 1);
    step(1, T_BODY, $urandom, 0);
    @(negedge clk);
    #2;
    reset = 1'b1; in_valid_i = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid_o),       64'(0));
    check("rst_out_flit",  64'(out_flit_o),        64'(0));
    check("rst_port_sel",  64'(port_sel_o),        64'(0));
    check("rst_pkt_en",    64'(PacketEnable_dw_o), 64'(0));
    check("rst_tailpass",  64'(Tailpassed_dw_o),   64'(0));
    check("rst_err",       64'(err_o),             64'(0));
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    dest(1, 3, p); step(1, T_HEAD, p, 1);
    step(1, T_TAIL, $urandom, 1);
    repeat (3) step(0, T_BODY, 32'h0, 1);

    // Random traffic, biased toward well-formed packets
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 9);
      if (in_pkt) typ = (r < 6) ? T_BODY : (r < 8) ? T_TAIL : (r == 8) ? T_HEAD : T_HT;
      else        typ = (r < 6) ? T_HEAD : (r < 8) ? T_HT : (r == 8) ? T_BODY : T_TAIL;
      step(($urandom_range(0, 7) != 0), typ, $urandom, ($urandom_range(0, 3) != 0));
    end
    repeat (4) step(0, T_BODY, 32'h0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
